// File: rtl/cam_pixel_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cam_pixel_packer
// Description : Samples an 8-bit camera bus in the clk domain, packs byte
//               pairs into 16-bit pixels tagged with an SRAM word address,
//               applies line/pixel decimation and buffers pixels in a FIFO
//               offered on a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_pixel_packer #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          LINE_SKIP  = 0,
    parameter int          PIX_SKIP   = 0,
    // Word address loaded at each frame start
    parameter logic [15:0] ADDR_INIT  = 16'h0000
) (
    input  logic        clk,
    input  logic        res,
    input  logic        pclk,
    input  logic        VSYNC,
    input  logic        HREF,
    input  logic [7:0]  cam_data,
    input  logic        enable,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [15:0] pix_data,
    output logic [15:0] pix_addr,
    output logic        frame_done,
    output logic        overflow
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] LINE_RELOAD = 16'(LINE_SKIP);
    localparam logic [15:0] PIX_RELOAD  = 16'(PIX_SKIP);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_FRAME = 3'd1;
    localparam logic [2:0] S_WAIT_LINE  = 3'd2;
    localparam logic [2:0] S_BYTE_HI    = 3'd3;
    localparam logic [2:0] S_BYTE_LO    = 3'd4;

    // ------------------------------------------------------------------
    // Camera bus synchronizers plus one history stage for edge detection
    // ------------------------------------------------------------------
    logic       pclk_s1_q, pclk_s2_q, pclk_prev_q;
    logic       vsync_s1_q, vsync_s2_q, vsync_prev_q;
    logic       href_s1_q, href_s2_q, href_prev_q;
    logic [7:0] data_s1_q, data_s2_q;

    // Two-flop synchronize every camera signal, keep previous value for edges
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pclk_s1_q    <= 1'b0;
            pclk_s2_q    <= 1'b0;
            pclk_prev_q  <= 1'b0;
            vsync_s1_q   <= 1'b0;
            vsync_s2_q   <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_s1_q    <= 1'b0;
            href_s2_q    <= 1'b0;
            href_prev_q  <= 1'b0;
            data_s1_q    <= 8'h00;
            data_s2_q    <= 8'h00;
        end else begin
            pclk_s1_q    <= pclk;
            pclk_s2_q    <= pclk_s1_q;
            pclk_prev_q  <= pclk_s2_q;
            vsync_s1_q   <= VSYNC;
            vsync_s2_q   <= vsync_s1_q;
            vsync_prev_q <= vsync_s2_q;
            href_s1_q    <= HREF;
            href_s2_q    <= href_s1_q;
            href_prev_q  <= href_s2_q;
            data_s1_q    <= cam_data;
            data_s2_q    <= data_s1_q;
        end
    end

    logic pclk_rise, vsync_rise, vsync_fall, href_rise, href_fall;
    assign pclk_rise  =  pclk_s2_q  & ~pclk_prev_q;
    assign vsync_rise =  vsync_s2_q & ~vsync_prev_q;
    assign vsync_fall = ~vsync_s2_q &  vsync_prev_q;
    assign href_rise  =  href_s2_q  & ~href_prev_q;
    assign href_fall  = ~href_s2_q  &  href_prev_q;

    // ------------------------------------------------------------------
    // FIFO pointers / status
    // ------------------------------------------------------------------
    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] fifo_count;
    logic        fifo_full, fifo_pop, can_push;
    logic [31:0] head_word;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_count == DEPTH_C);
    assign pix_valid  = (wr_ptr_q != rd_ptr_q);
    assign fifo_pop   = pix_valid & pix_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign can_push   = ~fifo_full | fifo_pop;
    assign head_word  = mem_q[rd_ptr_q[AW-1:0]];
    // Gate the head so outputs read zero while the FIFO is empty
    assign pix_data   = pix_valid ? head_word[31:16] : 16'h0000;
    assign pix_addr   = pix_valid ? head_word[15:0]  : 16'h0000;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic        overflow_q, overflow_d;
    logic        frame_done_q, frame_done_d;
    logic        push;
    logic [31:0] push_word;

    // Next-state logic: frame/line tracking, byte assembly and decimation
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        line_cnt_d   = line_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        hi_d         = hi_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        push         = 1'b0;
        push_word    = {hi_q, data_s2_q, addr_q};
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT_FRAME;
            end
            S_WAIT_FRAME: begin
                if (vsync_fall) begin
                    state_d    = S_WAIT_LINE;
                    addr_d     = ADDR_INIT;
                    line_cnt_d = 16'h0000;
                    pix_cnt_d  = 16'h0000;
                    overflow_d = 1'b0;
                end
            end
            S_WAIT_LINE, S_BYTE_HI, S_BYTE_LO: begin
                if (vsync_rise) begin
                    // End of frame wins over any line activity
                    frame_done_d = 1'b1;
                    state_d      = enable ? S_WAIT_FRAME : S_IDLE;
                end else begin
                    case (state_q)
                        S_WAIT_LINE: begin
                            if (href_rise) begin
                                if (line_cnt_q == 16'h0000) begin
                                    state_d    = S_BYTE_HI;
                                    line_cnt_d = LINE_RELOAD;
                                    pix_cnt_d  = 16'h0000;
                                end else begin
                                    line_cnt_d = line_cnt_q - 16'd1;
                                end
                            end
                        end
                        S_BYTE_HI: begin
                            if (href_fall) begin
                                state_d = S_WAIT_LINE;
                            end else if (pclk_rise && href_s2_q) begin
                                hi_d    = data_s2_q;
                                state_d = S_BYTE_LO;
                            end
                        end
                        S_BYTE_LO: begin
                            if (href_fall) begin
                                // Half pixel is simply abandoned
                                state_d = S_WAIT_LINE;
                            end else if (pclk_rise && href_s2_q) begin
                                state_d = S_BYTE_HI;
                                if (pix_cnt_q == 16'h0000) begin
                                    pix_cnt_d = PIX_RELOAD;
                                    if (can_push) begin
                                        push   = 1'b1;
                                        addr_d = addr_q + 16'd1;
                                    end else begin
                                        overflow_d = 1'b1;
                                    end
                                end else begin
                                    pix_cnt_d = pix_cnt_q - 16'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= S_IDLE;
            addr_q       <= 16'h0000;
            line_cnt_q   <= 16'h0000;
            pix_cnt_q    <= 16'h0000;
            hi_q         <= 8'h00;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            line_cnt_q   <= line_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            hi_q         <= hi_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    // FIFO pointer update
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents are qualified by the pointers so no reset needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_pixel_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cam_pixel_packer
// Description : Directed bench for cam_pixel_packer. Three instances share
//               one camera bus: A default, B with 1-of-2 line/pixel
//               decimation, C starting its addresses at 0xFFFE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_pixel_packer;

    logic       clk = 1'b0;
    logic       res, pclk, VSYNC, HREF, enable;
    logic [7:0] cam_data;
    logic       ready_a, ready_b, ready_c;

    logic        valid_a, valid_b, valid_c;
    logic [15:0] data_a, data_b, data_c, addr_a, addr_b, addr_c;
    logic        fd_a, fd_b, fd_c, ovf_a, ovf_b, ovf_c;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int fd_cnt_a = 0;
    int fd_cnt_b = 0;
    int fd_snap;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] q_c[$];

    always #5 clk = ~clk;

    cam_pixel_packer u_a (
        .clk(clk), .res(res), .pclk(pclk), .VSYNC(VSYNC), .HREF(HREF),
        .cam_data(cam_data), .enable(enable), .pix_valid(valid_a),
        .pix_ready(ready_a), .pix_data(data_a), .pix_addr(addr_a),
        .frame_done(fd_a), .overflow(ovf_a)
    );

    cam_pixel_packer #(.LINE_SKIP(1), .PIX_SKIP(1)) u_b (
        .clk(clk), .res(res), .pclk(pclk), .VSYNC(VSYNC), .HREF(HREF),
        .cam_data(cam_data), .enable(enable), .pix_valid(valid_b),
        .pix_ready(ready_b), .pix_data(data_b), .pix_addr(addr_b),
        .frame_done(fd_b), .overflow(ovf_b)
    );

    cam_pixel_packer #(.ADDR_INIT(16'hFFFE)) u_c (
        .clk(clk), .res(res), .pclk(pclk), .VSYNC(VSYNC), .HREF(HREF),
        .cam_data(cam_data), .enable(enable), .pix_valid(valid_c),
        .pix_ready(ready_c), .pix_data(data_c), .pix_addr(addr_c),
        .frame_done(fd_c), .overflow(ovf_c)
    );

    // Record every accepted pixel and count frame_done pulses
    always @(negedge clk) begin
        if (valid_a && ready_a) q_a.push_back({data_a, addr_a});
        if (valid_b && ready_b) q_b.push_back({data_b, addr_b});
        if (valid_c && ready_c) q_c.push_back({data_c, addr_c});
        if (fd_a) fd_cnt_a++;
        if (fd_b) fd_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input int sel, input string tag, input logic [15:0] d, input logic [15:0] a);
        logic [31:0] w;
        w = 32'hDEAD_BEEF;
        case (sel)
            0: if (q_a.size() > 0) w = q_a.pop_front();
            1: if (q_b.size() > 0) w = q_b.pop_front();
            2: if (q_c.size() > 0) w = q_c.pop_front();
            default: ;
        endcase
        check(tag, w, {d, a});
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        pclk = 1'b0; cam_data = b; #40;
        pclk = 1'b1; #40;
    endtask

    task automatic send_line(input int n, input logic [7:0] first);
        HREF = 1'b1; #80;
        for (int i = 0; i < n; i++) send_byte(first + 8'(i));
        pclk = 1'b0; #40;
        HREF = 1'b0; #200;
    endtask

    // Rising VSYNC ends any frame in progress; falling VSYNC starts the next
    task automatic frame_start();
        VSYNC = 1'b1; #200;
        VSYNC = 1'b0; #200;
    endtask

    task automatic clear_queues();
        q_a.delete(); q_b.delete(); q_c.delete();
    endtask

    initial begin
        res = 1'b0; pclk = 1'b0; VSYNC = 1'b0; HREF = 1'b0; enable = 1'b0;
        cam_data = 8'h00; ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;

        // Reset state
        clks(5);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_data",  {16'd0, data_a},  32'd0);
        check("rst_addr",  {16'd0, addr_a},  32'd0);
        check("rst_fdone", {31'd0, fd_a},    32'd0);
        check("rst_ovf",   {31'd0, ovf_a},   32'd0);
        res = 1'b1;
        enable = 1'b1;
        clks(5);

        // One frame, 2 lines x 4 pixels, free-flowing sink
        clear_queues();
        fd_snap = fd_cnt_a;
        frame_start();
        send_line(8, 8'h01);
        send_line(8, 8'h09);
        VSYNC = 1'b1; #200;
        clks(20);
        check("t2_count", q_a.size(), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check_pop(0, "t2_pix", {8'(2*k+1), 8'(2*k+2)}, 16'(k));
        end
        check("t2_fdone", fd_cnt_a - fd_snap, 32'd1);
        // Address wrap on the instance starting at 0xFFFE
        check_pop(2, "t6_wrap0", 16'h0102, 16'hFFFE);
        check_pop(2, "t6_wrap1", 16'h0304, 16'hFFFF);
        check_pop(2, "t6_wrap2", 16'h0506, 16'h0000);

        // Decimation: 4 lines x 4 pixels, keep lines 0,2 and pixels 0,2
        clear_queues();
        fd_snap = fd_cnt_b;
        VSYNC = 1'b0; #200;
        send_line(8, 8'h01);
        send_line(8, 8'h09);
        send_line(8, 8'h11);
        send_line(8, 8'h19);
        VSYNC = 1'b1; #200;
        clks(20);
        check("t5_count", q_b.size(), 32'd4);
        check_pop(1, "t5_p0", 16'h0102, 16'd0);
        check_pop(1, "t5_p1", 16'h0506, 16'd1);
        check_pop(1, "t5_p2", 16'h1112, 16'd2);
        check_pop(1, "t5_p3", 16'h1516, 16'd3);
        check("t5_fdone", fd_cnt_b - fd_snap, 32'd1);

        // Odd byte count: line of 3 bytes, then a full line
        clear_queues();
        VSYNC = 1'b0; #200;
        send_line(3, 8'hA1);
        send_line(4, 8'hB1);
        clks(20);
        check("t4_count", q_a.size(), 32'd3);
        check_pop(0, "t4_p0", 16'hA1A2, 16'd0);
        check_pop(0, "t4_p1", 16'hB1B2, 16'd1);
        check_pop(0, "t4_p2", 16'hB3B4, 16'd2);

        // Stalled sink: 6-pixel line into a 4-entry FIFO
        clear_queues();
        @(posedge clk); #1; ready_a = 1'b0;
        frame_start();
        send_line(12, 8'h01);
        check("t3_valid", {31'd0, valid_a}, 32'd1);
        check("t3_head",  {16'd0, data_a},  32'h0102);
        check("t3_haddr", {16'd0, addr_a},  32'd0);
        check("t3_ovf",   {31'd0, ovf_a},   32'd1);
        @(posedge clk); #1; ready_a = 1'b1;
        clks(20);
        check("t3_count", q_a.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_pop(0, "t3_pix", {8'(2*k+1), 8'(2*k+2)}, 16'(k));
        end
        send_line(2, 8'hC1);
        clks(20);
        check_pop(0, "t3_next_addr", 16'hC1C2, 16'd4);
        check("t3_ovf_sticky", {31'd0, ovf_a}, 32'd1);
        frame_start();
        check("t3_ovf_clr", {31'd0, ovf_a}, 32'd0);

        // Reset mid-line while in BYTE_LO with data buffered
        clear_queues();
        @(posedge clk); #1; ready_a = 1'b0;
        HREF = 1'b1; #80;
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
        check("t1_pre_valid", {31'd0, valid_a}, 32'd1);
        res = 1'b0;
        clks(3);
        check("t1_valid", {31'd0, valid_a}, 32'd0);
        check("t1_data",  {16'd0, data_a},  32'd0);
        check("t1_addr",  {16'd0, addr_a},  32'd0);
        check("t1_ovf",   {31'd0, ovf_a},   32'd0);
        check("t1_fdone", {31'd0, fd_a},    32'd0);
        #2; res = 1'b1;
        @(posedge clk); #1; ready_a = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'h16 + 8'(i));
        pclk = 1'b0; #40;
        HREF = 1'b0; #200;
        send_line(4, 8'h31);
        clks(20);
        check("t1_no_push", q_a.size(), 32'd0);
        frame_start();
        send_line(4, 8'h21);
        clks(20);
        check("t1_count", q_a.size(), 32'd2);
        check_pop(0, "t1_p0", 16'h2122, 16'd0);
        check_pop(0, "t1_p1", 16'h2324, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
